// File: rtl/ghost_sd_pkg.sv
// ghost_sd_pkg: shared mode encodings and FSM states for the SD cipher data path
package ghost_sd_pkg;
   localparam int MODE_OFB = 0;
   localparam int MODE_CTR = 1;
   typedef enum logic [2:0] {ST_IDLE, ST_GEN, ST_WAIT, ST_XOR, ST_DONE} gsx_state_t;
endpackage

// File: rtl/gost_stream_xor.sv
// gost_stream_xor: XORs one sector of raw RAM words with a GOST OFB/CTR keystream,
// one 64-bit cipher block per N = 64/DATA_W words, chain register kept across sectors
module gost_stream_xor
   import ghost_sd_pkg::*;
#(
   parameter int DATA_W      = 4,
   parameter int BLOCK_WORDS = 1024,
   parameter int MODE        = MODE_OFB,
   parameter int ADDR_W      = $clog2(BLOCK_WORDS)
) (
   input  logic              iclk,
   input  logic              irst,
   input  logic              istart,
   input  logic              inew_iv,
   input  logic [63:0]       iiv,
   output logic              ogost_start,
   output logic [63:0]       ogost_block,
   input  logic [63:0]       igost_block,
   input  logic              igost_done,
   output logic [ADDR_W-1:0] oraddr,
   input  logic [DATA_W-1:0] irdata,
   output logic [ADDR_W-1:0] owaddr,
   output logic [DATA_W-1:0] owdata,
   output logic              owrite_en,
   output logic              obusy,
   output logic              odone
);
   localparam int N     = 64 / DATA_W;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(BLOCK_WORDS - N);

   if (64 % DATA_W != 0) begin : g_bad_data_w
      $error("gost_stream_xor: DATA_W must divide 64");
   end
   if ((BLOCK_WORDS * DATA_W) % 64 != 0) begin : g_bad_block_words
      $error("gost_stream_xor: BLOCK_WORDS*DATA_W must be a multiple of 64");
   end
   if (MODE != MODE_OFB && MODE != MODE_CTR) begin : g_bad_mode
      $error("gost_stream_xor: MODE must be OFB or CTR");
   end
   if (ADDR_W != $clog2(BLOCK_WORDS)) begin : g_bad_addr_w
      $error("gost_stream_xor: ADDR_W is derived and must not be overridden");
   end

   gsx_state_t        state, state_nx;
   logic [63:0]       s, k;
   logic [ADDR_W-1:0] a, wa;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] kw;
   logic              wr, last_word;

   always_comb begin
      last_word   = state == ST_XOR && cnt == CNT_W'(N - 1);
      state_nx    = state;
      unique case (state)
         ST_IDLE: state_nx = istart ? ST_GEN : ST_IDLE;
         ST_GEN:  state_nx = ST_WAIT;
         ST_WAIT: state_nx = igost_done ? ST_XOR : ST_WAIT;
         ST_XOR:  state_nx = last_word ? (a == LAST_A ? ST_DONE : ST_GEN) : ST_XOR;
         ST_DONE: state_nx = wr ? ST_DONE : ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
      ogost_start = state == ST_GEN;
      ogost_block = s;
      oraddr      = state == ST_XOR ? a + ADDR_W'(cnt) : '0;
      owaddr      = wa;
      owdata      = wr ? irdata ^ kw : '0;
      owrite_en   = wr;
      obusy       = state != ST_IDLE;
      // DONE holds one extra cycle while the final word drains, so odone follows the last write
      odone       = state == ST_DONE && !wr;
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         state <= ST_IDLE;
         s     <= '0;
         k     <= '0;
         a     <= '0;
         cnt   <= '0;
         wr    <= 1'b0;
         wa    <= '0;
         kw    <= '0;
      end else begin
         state <= state_nx;
         wr    <= state == ST_XOR;
         wa    <= oraddr;
         kw    <= k[63 -: DATA_W];
         if (state == ST_IDLE && istart) begin
            a <= '0;
            if (inew_iv) s <= iiv;
         end
         if (state == ST_WAIT && igost_done) begin
            k <= igost_block;
            s <= (MODE == MODE_CTR) ? s + 64'd1 : igost_block;
         end
         if (state == ST_XOR) begin
            k   <= k << DATA_W;
            cnt <= last_word ? '0 : cnt + 1'b1;
            if (last_word) a <= a + ADDR_W'(N);
         end
      end
   end
endmodule

// File: tb/tb_gost_stream_xor.sv
// tb_gost_stream_xor: OFB and CTR instances run side by side against a ~x stub cipher,
// with hand-computed sector vectors plus a keystream reference model
`timescale 1ns/1ps
module tb_gost_stream_xor;
   import ghost_sd_pkg::*;
   localparam int DW = 4;
   localparam int BW = 32;
   localparam int AW = 5;

   logic iclk = 1'b0, irst = 1'b1, istart = 1'b0, inew_iv = 1'b0;
   logic [63:0] iiv = '0;
   logic gst [2], gd [2], gpend [2], we [2], busy [2], done [2];
   logic [63:0] gblk [2], gbi [2], gin [2], ms [2];
   logic [63:0] glog [2][2];
   logic [AW-1:0] ra [2], wa [2];
   logic [DW-1:0] rd [2], wd [2];
   logic [DW-1:0] ram [BW];
   logic [DW-1:0] exp_w [2][BW];
   logic [DW-1:0] got_w [2][BW];
   int gcnt [2], wcnt [2], dcnt [2], gidx [2];
   int n_chk = 0, n_err = 0, lat = 3, wsave = 0;
   bit rnd_lat = 1'b0;

   always #5 iclk = ~iclk;

   gost_stream_xor #(.DATA_W(DW), .BLOCK_WORDS(BW), .MODE(MODE_OFB)) u_ofb (
      .iclk(iclk), .irst(irst), .istart(istart), .inew_iv(inew_iv), .iiv(iiv),
      .ogost_start(gst[0]), .ogost_block(gblk[0]), .igost_block(gbi[0]), .igost_done(gd[0]),
      .oraddr(ra[0]), .irdata(rd[0]), .owaddr(wa[0]), .owdata(wd[0]), .owrite_en(we[0]),
      .obusy(busy[0]), .odone(done[0]));

   gost_stream_xor #(.DATA_W(DW), .BLOCK_WORDS(BW), .MODE(MODE_CTR)) u_ctr (
      .iclk(iclk), .irst(irst), .istart(istart), .inew_iv(inew_iv), .iiv(iiv),
      .ogost_start(gst[1]), .ogost_block(gblk[1]), .igost_block(gbi[1]), .igost_done(gd[1]),
      .oraddr(ra[1]), .irdata(rd[1]), .owaddr(wa[1]), .owdata(wd[1]), .owrite_en(we[1]),
      .obusy(busy[1]), .odone(done[1]));

   // stub cipher: returns ~block some cycles after the start pulse
   always @(posedge iclk or posedge irst)
      for (int j = 0; j < 2; j++)
         if (irst) begin
            gd[j]    <= 1'b0;
            gpend[j] <= 1'b0;
            gcnt[j]  <= 0;
            gbi[j]   <= '0;
            gin[j]   <= '0;
         end else begin
            gd[j] <= 1'b0;
            if (gst[j]) begin
               gin[j]   <= gblk[j];
               gpend[j] <= 1'b1;
               gcnt[j]  <= rnd_lat ? int'($urandom_range(20, 1)) : lat;
            end else if (gpend[j]) begin
               gcnt[j] <= gcnt[j] - 1;
               if (gcnt[j] == 1) begin
                  gd[j]    <= 1'b1;
                  gbi[j]   <= ~gin[j];
                  gpend[j] <= 1'b0;
               end
            end
         end

   always @(posedge iclk)
      for (int j = 0; j < 2; j++) rd[j] <= ram[ra[j]];

   always @(negedge iclk)
      if (!irst)
         for (int j = 0; j < 2; j++) begin
            if (we[j]) begin
               check($sformatf("order%0d", j), 64'(wa[j]), 64'(wcnt[j] % BW));
               got_w[j][wa[j]] = wd[j];
               wcnt[j]++;
            end
            if (done[j]) dcnt[j]++;
            if (gst[j]) begin
               glog[j][gidx[j] % 2] = gblk[j];
               gidx[j]++;
            end
            if (gpend[j] || gd[j]) check($sformatf("gblk_stable%0d", j), gblk[j], gin[j]);
         end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   task automatic check_idle(input string tag);
      for (int j = 0; j < 2; j++) begin
         check($sformatf("%s_blk%0d", tag, j), gblk[j], 64'd0);
         check($sformatf("%s_out%0d", tag, j),
               64'({busy[j], done[j], we[j], gst[j], ra[j], wa[j], wd[j]}), 64'd0);
      end
   endtask

   task automatic start_sector(input logic niv, input logic [63:0] iv);
      logic [63:0] k;
      for (int j = 0; j < 2; j++) begin
         wcnt[j] = 0;
         dcnt[j] = 0;
         gidx[j] = 0;
         for (int w = 0; w < BW; w++) got_w[j][w] = 'x;
         if (niv) ms[j] = iv;
         for (int b = 0; b < BW / 16; b++) begin
            k     = ~ms[j];
            ms[j] = (j == 1) ? ms[j] + 64'd1 : k;
            for (int i = 0; i < 16; i++) exp_w[j][b*16+i] = ram[b*16+i] ^ k[63-4*i -: 4];
         end
      end
      @(negedge iclk);
      istart  = 1'b1;
      inew_iv = niv;
      iiv     = iv;
      @(negedge iclk);
      istart = 1'b0;
      check("busy_rise", 64'(busy[0]), 64'd1);
   endtask

   task automatic wait_done(input bit poke);
      int c = 0;
      while (c < 4000 && !(dcnt[0] > 0 && dcnt[1] > 0)) begin
         @(posedge iclk);
         #2;
         c++;
         if (poke && wcnt[0] == 1) begin
            istart  = 1'b1;
            inew_iv = 1'b1;
            iiv     = 64'hDEAD_BEEF_0BAD_F00D;
            @(posedge iclk);
            #2;
            istart = 1'b0;
            poke   = 1'b0;
         end
      end
      check("sector_timeout", 64'(c < 4000), 64'd1);
      repeat (5) @(negedge iclk);
   endtask

   task automatic check_sector();
      for (int j = 0; j < 2; j++) begin
         check($sformatf("writes%0d", j), 64'(wcnt[j]), 64'(BW));
         check($sformatf("odone%0d", j), 64'(dcnt[j]), 64'd1);
         check($sformatf("busy_fall%0d", j), 64'(busy[j]), 64'd0);
         for (int w = 0; w < BW; w++)
            check($sformatf("d%0d_w%0d", j, w), 64'(got_w[j][w]), 64'(exp_w[j][w]));
      end
   endtask

   initial begin
      int c;
      ms[0] = '0;
      ms[1] = '0;
      repeat (2) @(negedge iclk);
      check_idle("reset");
      irst = 1'b0;

      for (int w = 0; w < BW; w++) ram[w] = 4'hA;
      start_sector(1'b1, 64'd0);
      wait_done(1'b0);
      check_sector();
      for (int w = 0; w < BW; w++) check("ofb_new", 64'(got_w[0][w]), w < 16 ? 64'h5 : 64'hA);
      check("ofb_blk1_in", glog[0][1], '1);

      start_sector(1'b0, 64'h1234);
      wait_done(1'b0);
      check_sector();
      check("ofb_cont_in", glog[0][0], 64'd0);
      for (int w = 0; w < BW; w++) check("ofb_cont", 64'(got_w[0][w]), w < 16 ? 64'h5 : 64'hA);

      for (int w = 0; w < BW; w++) ram[w] = 4'h0;
      start_sector(1'b1, 64'd0);
      wait_done(1'b0);
      check_sector();
      check("ctr_blk1_in", glog[1][1], 64'd1);
      for (int w = 0; w < BW; w++) check("ctr_new", 64'(got_w[1][w]), w < 31 ? 64'hF : 64'hE);

      start_sector(1'b1, '1);
      wait_done(1'b0);
      check_sector();
      check("ctr_wrap_in0", glog[1][0], '1);
      check("ctr_wrap_in1", glog[1][1], 64'd0);
      for (int w = 0; w < BW; w++) check("ctr_wrap", 64'(got_w[1][w]), w < 16 ? 64'h0 : 64'hF);

      for (int w = 0; w < BW; w++) ram[w] = 4'($urandom);
      start_sector(1'b1, 64'h0123_4567_89AB_CDEF);
      wait_done(1'b1);
      check_sector();

      start_sector(1'b1, 64'h5555_AAAA_0F0F_F0F0);
      c = 0;
      while (wcnt[0] < 6 && c < 2000) begin
         @(posedge iclk);
         #2;
         c++;
      end
      irst = 1'b1;
      #1;
      check_idle("abort");
      wsave = wcnt[0];
      check("abort_point", 64'(wsave), 64'd6);
      repeat (3) @(negedge iclk);
      irst = 1'b0;
      repeat (20) @(negedge iclk);
      check("abort_no_writes", 64'(wcnt[0]), 64'(wsave));
      check("abort_no_done", 64'(dcnt[0]), 64'd0);
      ms[0] = '0;
      ms[1] = '0;
      start_sector(1'b0, '1);
      wait_done(1'b0);
      check_sector();
      check("after_abort_in_ofb", glog[0][0], 64'd0);
      check("after_abort_in_ctr", glog[1][0], 64'd0);

      rnd_lat = 1'b1;
      repeat (4) begin
         for (int w = 0; w < BW; w++) ram[w] = 4'($urandom);
         start_sector(1'($urandom_range(1, 0)), {$urandom, $urandom});
         wait_done(1'b0);
         check_sector();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/gost_stream_xor.md
# gost_stream_xor

Parametrised GOST stream-cipher engine for the SD data path. It reads plaintext or ciphertext words from the raw sector RAM and XORs each word with a GOST-generated keystream in OFB or CTR mode. The result is written to the processed sector RAM. The keystream chain can be carried across consecutive sectors. This block replaces the free-running IV re-encryption loop in the top level. The `gost` core sits outside this block and is driven through a start/done handshake.

## Interface
Parameters:
- `DATA_W`, default 4: word width of the sector RAMs; must divide 64.
- `BLOCK_WORDS`, default 1024: words per sector (512 bytes at 4 bits); `BLOCK_WORDS*DATA_W` must be a multiple of 64.
- `MODE`, default 0: 0 = OFB, 1 = CTR.
- `ADDR_W`, default `$clog2(BLOCK_WORDS)`: derived; do not override.

Ports:
- `iclk`  in  1  system clock (36 MHz).
- `irst`  in  1  reset; asynchronous, active-high.
- `istart`  in  1  one-cycle request to process one sector.
- `inew_iv`  in  1  sampled with `istart`: 1 = load `iiv`, 0 = continue the saved chain.
- `iiv`  in  64  initial value (OFB register or CTR counter).
- `ogost_start`  out  1  one-cycle start pulse to the `gost` core.
- `ogost_block`  out  64  cipher input block.
- `igost_block`  in  64  cipher output block; valid while `igost_done` is high.
- `igost_done`  in  1  cipher completion pulse.
- `oraddr`  out  ADDR_W  raw RAM read address; the RAM has 1-cycle read latency.
- `irdata`  in  DATA_W  raw RAM read data.
- `owaddr`  out  ADDR_W  processed RAM write address.
- `owdata`  out  DATA_W  processed RAM write data.
- `owrite_en`  out  1  processed RAM write strobe.
- `obusy`  out  1  sector in progress.
- `odone`  out  1  one-cycle pulse when the sector is complete.

## Operation
States are IDLE, GEN, WAIT, XOR and DONE.

**IDLE**
- An `istart` pulse is accepted only in IDLE.
- If `inew_iv`=1, load `iiv` into the chain register `S`. Otherwise keep `S`.
- Clear the word address `A` to 0 and go to GEN.

**GEN**
- Drive `ogost_block` = `S` and pulse `ogost_start` for one cycle.
- Go to WAIT.

**WAIT**
- On `igost_done`, capture `igost_block` into the keystream register `K`.
- OFB: `S` <= `igost_block`.
- CTR: `S` <= `S`+1, mod 2^64 (wraps silently).
- Go to XOR.

**XOR**
- Runs for N = 64/`DATA_W` cycles.
- Issue `oraddr`=`A`+i for word i. Word 0 uses `K[63:64-DATA_W]`, i.e. MSB first.
- A one-stage pipeline writes `owdata` = `irdata` ^ keystream word at `owaddr` = the address issued in the previous cycle.
- After word N-1: if `A`+N = `BLOCK_WORDS`, go to DONE. Otherwise `A` <= `A`+N and go to GEN.
- The pending write issues in the first cycle of GEN or DONE.

**DONE**
- Pulse `odone` and return to IDLE.
- `S` is retained for continuation.

Ignored events:
- `igost_done` outside WAIT.
- `istart` outside IDLE. It is not queued.

## Timing
- Reset values: all outputs 0; `S`, `K` and `A` = 0; state IDLE. Reset mid-sector aborts immediately with no further writes, and a later continue starts from `S`=0.
- `obusy` rises in the cycle after `istart` is accepted and falls in the cycle after `odone`.
- `ogost_start` is high in the cycle after IDLE or XOR exit. `ogost_block` is stable from that cycle until `igost_done`.
- `owrite_en` pulses exactly `BLOCK_WORDS` times per sector, in ascending address order, never two to the same address.
- `odone` is high in the cycle after the final `owrite_en`.
- Sector latency is (`BLOCK_WORDS`/N)·(2 + gost latency + N) + 1 cycles from `istart`.
- `igost_done` arriving in the same cycle as `ogost_start`: accepted only from the next cycle (WAIT entry).

## Structure
- The mode encodings `MODE_OFB`=0 and `MODE_CTR`=1 and the state enumeration go in the shared `ghost_sd_pkg`.
- Parameter legality checks are elaboration-time assertions.
- No sub-module is needed. The `gost` core and both `ram_4k_block` instances are instantiated by the top level and connected to this block.

## Test plan
Bench setup: `DATA_W`=4, `BLOCK_WORDS`=32. A stub cipher returns ~x three cycles after start.

- **OFB, new IV:** `MODE`=0, `iiv`=0, raw all 0xA → words 0–15 = 0x5, words 16–31 = 0xA; 32 writes; `odone` once.
- **OFB continuation:** repeat with `inew_iv`=0 → first gost input = 64'h0, output again 16×0x5 then 16×0xA.
- **CTR, new IV:** `MODE`=1, `iiv`=0, raw all 0 → words 0–30 = 0xF, word 31 = 0xE. Also `iiv`=64'hFFFF_FFFF_FFFF_FFFF → counter wraps to 0 for block 2.
- **Busy `istart`:** pulse `istart` during XOR of block 1 → ignored; exactly 32 writes and one `odone`.
- **Reset mid-sector:** assert `irst` after word 5 is written → all outputs 0 the same cycle, no further writes. A new `istart` then completes normally.
- **Ordering:** random raw data and random gost latency 1–20 cycles → the scoreboard matches the reference XOR model, and `ogost_block` is stable across each wait.
